mmio_store_buffer: RTL and testbench
====================================

Name: mmio_store_buffer

Overview:
- Data-side neighbour of the single-cycle core. It consumes the core's MemWrite, ALUResult (address) and WriteData, and produces the ReadData the core reads back.
- Splits each core access between data RAM and a small MMIO window.
- Writes to the TXDATA register are queued in a FIFO and drained to a slow peripheral over a valid/ready handshake.
- The core never stalls, so a full buffer drops the write and sets a sticky overflow flag.

Parameters:
- MMIO_BASE, 32'hFFFF_0000: byte base of the 16-byte MMIO window; must be 16-byte aligned.
- FIFO_DEPTH, 4: store-buffer entries; power of two, minimum 2.

Ports:
- clk  in  1  core clock, rising edge
- reset  in  1  asynchronous, active-low reset (0 = reset)
- MemWrite  in  1  core store strobe
- ALUResult  in  32  core byte address
- WriteData  in  32  core store data
- RamReadData  in  32  read data from data RAM
- RamWE  out  1  RAM write enable = MemWrite & ~mmio_hit
- ReadData  out  32  read data returned to the core
- bus_valid  out  1  head entry available
- bus_data  out  32  head entry data
- bus_ready  in  1  peripheral accepts the head entry

Behaviour:
- mmio_hit = (ALUResult[31:4] == MMIO_BASE[31:4]). Register offset = ALUResult[3:0]; bits [1:0] are ignored, so access is word-only.
- Register map:
  - 0x0 TXDATA: write only; reads return 0.
  - 0x4 STATUS: read only. [0] full, [1] empty, [2] overflow, [15:8] count (zero-extended), all other bits 0.
  - 0x8 CTRL: a write with bit0=1 clears overflow; reads return 0.
  - 0xC: reserved; reads 0, writes ignored.
- ReadData is combinational: the STATUS/0 value when mmio_hit, else RamReadData. MMIO reads have no side effects.
- Push: MemWrite & mmio_hit & offset==0x0 & (!full | pop). A push stores WriteData at the tail on the clock edge.
- Drop: MemWrite & mmio_hit & offset==0x0 & full & !pop. The data is discarded and overflow is set to 1 on that edge.
- Pop: bus_valid & bus_ready; the head advances on the edge.
- bus_valid = !empty; bus_data = storage[head], driven from registers with no combinational path from WriteData.
- Latency: a word pushed at edge N is visible on bus_valid/bus_data after edge N, i.e. from cycle N+1.
- Push and pop in the same cycle:
  - Both take effect and count is unchanged.
  - If the FIFO is full, the push is accepted (no overflow).
  - If the FIFO is empty, pop is impossible because bus_valid is 0.
- Pointers: head/tail are log2(FIFO_DEPTH) bits and wrap modulo FIFO_DEPTH. count is log2(FIFO_DEPTH)+1 bits, range 0..FIFO_DEPTH. full = (count == FIFO_DEPTH); empty = (count == 0).
- bus_data must remain stable while bus_valid=1 and bus_ready=0.
- overflow clearing: only a CTRL write with bit0=1 clears it. A drop and a clear cannot coincide (one store per cycle).
- Reset, asserted at any time including mid-drain:
  - head=tail=count=0, overflow=0, bus_valid=0.
  - Storage contents are don't-care and bus_data reads X-free 0.
  - Words in flight are lost.
- RamWE is combinational and independent of reset state.

Optional Feature:
- Macro MMIO_STORE_BUFFER_IRQ_EN.
- When defined:
  - Adds output port irq (1 bit) and CTRL bit1 = ie, a register with reset value 0 that is written on any CTRL write.
  - irq is registered: irq <= overflow_next | (ie_next & empty_next), reset 0.
  - STATUS[3] reads ie.
- When undefined: no irq port, CTRL bit1 is ignored, STATUS[3] reads 0.

Decomposition:
- Shared package mmio_pkg holds:
  - offset constants OFF_TXDATA, OFF_STATUS, OFF_CTRL
  - STATUS bit positions (ST_FULL, ST_EMPTY, ST_OVF, ST_IE, ST_COUNT_LSB)
  - CTRL bit positions (CTRL_OVF_CLR, CTRL_IE)
- One sub-module: sync_fifo (parameters WIDTH, DEPTH; push/pop/full/empty/count/head_data). mmio_store_buffer holds the decode, overflow/ie flags and read mux.

Test Plan:
- Reset then idle: bus_valid=0. Read 0xFFFF_0004 -> ReadData=32'h0000_0002 (empty). RAM address 0x0000_0040 read -> ReadData=RamReadData; store there -> RamWE=1.
- Store 0xA5A5_0001 to 0xFFFF_0000 with bus_ready=0 -> RamWE=0; next cycle bus_valid=1, bus_data=0xA5A5_0001, STATUS count=1; data held stable over 5 cycles.
- Push 5 words (1..5) with bus_ready=0 -> 4 queued. STATUS=32'h0000_0405 (count=4, overflow, full); drain order 1,2,3,4.
- FIFO full, bus_ready=1 and push 0x99 in the same cycle -> count stays 4, overflow stays 0, 0x99 emerges last.
- Set overflow, write 0x1 to 0xFFFF_0008 -> STATUS[2]=0. Pull reset low mid-drain with 3 entries -> bus_valid=0 immediately, STATUS=0x2 after release.
- With MMIO_STORE_BUFFER_IRQ_EN: write 0x2 to CTRL on an empty FIFO -> irq=1 next cycle; push one word -> irq=0 after the push edge.

Source files
------------

// File: rtl/mmio_pkg.sv
// Register map constants and STATUS packing shared by the MMIO store buffer.
package mmio_pkg;

  localparam logic [3:0] OFF_TXDATA = 4'h0;
  localparam logic [3:0] OFF_STATUS = 4'h4;
  localparam logic [3:0] OFF_CTRL   = 4'h8;

  localparam int ST_FULL      = 0;
  localparam int ST_EMPTY     = 1;
  localparam int ST_OVF       = 2;
  localparam int ST_IE        = 3;
  localparam int ST_COUNT_LSB = 8;

  localparam int CTRL_OVF_CLR = 0;
  localparam int CTRL_IE      = 1;

  function automatic logic [31:0] pack_status(input logic full, input logic empty,
                                              input logic ovf, input logic ie,
                                              input logic [7:0] count);
    logic [31:0] s;
    s                    = '0;
    s[ST_FULL]           = full;
    s[ST_EMPTY]          = empty;
    s[ST_OVF]            = ovf;
    s[ST_IE]             = ie;
    s[ST_COUNT_LSB +: 8] = count;
    return s;
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Register-based FIFO with a combinational head view; head_data is forced to 0 when empty.
module sync_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   push,
  input  logic                   pop,
  input  logic [WIDTH-1:0]       wdata,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count,
  output logic [WIDTH-1:0]       head_data
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] storage [DEPTH];
  logic [AW-1:0]    head_reg, tail_reg;
  logic [AW:0]      count_reg;
  logic             push_ok, pop_ok;

  assign full    = (count_reg == (AW+1)'(DEPTH));
  assign empty   = (count_reg == '0);
  assign pop_ok  = pop & ~empty;
  assign push_ok = push & (~full | pop_ok);

  // Storage is deliberately not reset; head_data masks stale contents instead.
  always_ff @(posedge clk) begin
    if (push_ok) storage[tail_reg] <= wdata;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head_reg  <= '0;
      tail_reg  <= '0;
      count_reg <= '0;
    end else begin
      if (push_ok) tail_reg <= tail_reg + AW'(1);
      if (pop_ok)  head_reg <= head_reg + AW'(1);
      count_reg <= count_reg + (AW+1)'(push_ok) - (AW+1)'(pop_ok);
    end
  end

  assign count     = count_reg;
  assign head_data = empty ? '0 : storage[head_reg];

endmodule

// File: rtl/mmio_store_buffer.sv
// MMIO decode, overflow/ie flags and read mux in front of a TX store FIFO.
// Optional interrupt output enabled by defining MMIO_STORE_BUFFER_IRQ_EN.
module mmio_store_buffer
  import mmio_pkg::*;
#(
  parameter logic [31:0] MMIO_BASE  = 32'hFFFF_0000,
  parameter int          FIFO_DEPTH = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        MemWrite,
  input  logic [31:0] ALUResult,
  input  logic [31:0] WriteData,
  input  logic [31:0] RamReadData,
  output logic        RamWE,
  output logic [31:0] ReadData,
  output logic        bus_valid,
  output logic [31:0] bus_data,
  input  logic        bus_ready
`ifdef MMIO_STORE_BUFFER_IRQ_EN
  ,
  output logic        irq
`endif
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  logic          mmio_hit;
  logic [3:0]    offset;
  logic          tx_wr, ctrl_wr;
  logic          push, pop, drop;
  logic          full, empty;
  logic [CW-1:0] count;
  logic          overflow_reg, overflow_next;
  logic          ie_val;
  logic [31:0]   status;
  logic          unused_ok;

  assign mmio_hit = (ALUResult[31:4] == MMIO_BASE[31:4]);
  assign offset   = {ALUResult[3:2], 2'b00};
  assign tx_wr    = MemWrite & mmio_hit & (offset == OFF_TXDATA);
  assign ctrl_wr  = MemWrite & mmio_hit & (offset == OFF_CTRL);
  assign RamWE    = MemWrite & ~mmio_hit;

  assign pop  = bus_valid & bus_ready;
  assign push = tx_wr & (~full | pop);
  assign drop = tx_wr & full & ~pop;

  sync_fifo #(
    .WIDTH(32),
    .DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clk      (clk),
    .rst_n    (reset),
    .push     (push),
    .pop      (pop),
    .wdata    (WriteData),
    .full     (full),
    .empty    (empty),
    .count    (count),
    .head_data(bus_data)
  );

  assign bus_valid = ~empty;

  always_comb begin
    overflow_next = overflow_reg;
    if (drop)                                   overflow_next = 1'b1;
    else if (ctrl_wr && WriteData[CTRL_OVF_CLR]) overflow_next = 1'b0;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) overflow_reg <= 1'b0;
    else        overflow_reg <= overflow_next;
  end

`ifdef MMIO_STORE_BUFFER_IRQ_EN
  logic          ie_reg, ie_next, irq_reg;
  logic [CW-1:0] count_next;

  assign ie_next    = ctrl_wr ? WriteData[CTRL_IE] : ie_reg;
  assign count_next = count + CW'(push) - CW'(pop);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ie_reg  <= 1'b0;
      irq_reg <= 1'b0;
    end else begin
      ie_reg  <= ie_next;
      irq_reg <= overflow_next | (ie_next & (count_next == '0));
    end
  end

  assign ie_val = ie_reg;
  assign irq    = irq_reg;
`else
  assign ie_val = 1'b0;
`endif

  assign status    = pack_status(full, empty, overflow_reg, ie_val, 8'(count));
  assign unused_ok = ^{ALUResult[1:0], WriteData[CTRL_IE]};

  // MMIO reads are side-effect free: only STATUS returns non-zero data.
  always_comb begin
    ReadData = RamReadData;
    if (mmio_hit) ReadData = (offset == OFF_STATUS) ? status : 32'h0;
  end

endmodule

// File: tb/tb_mmio_store_buffer.sv
// Scoreboard bench for mmio_store_buffer; irq checks compiled in with MMIO_STORE_BUFFER_IRQ_EN.
module tb_mmio_store_buffer;

  logic        clk = 1'b0;
  logic        reset;
  logic        MemWrite;
  logic [31:0] ALUResult, WriteData, RamReadData;
  logic        RamWE;
  logic [31:0] ReadData;
  logic        bus_valid;
  logic [31:0] bus_data;
  logic        bus_ready;
`ifdef MMIO_STORE_BUFFER_IRQ_EN
  logic        irq;
`endif

  int tests = 0;
  int fails = 0;
  logic [31:0] exp_q[$];

  mmio_store_buffer dut (
    .clk        (clk),
    .reset      (reset),
    .MemWrite   (MemWrite),
    .ALUResult  (ALUResult),
    .WriteData  (WriteData),
    .RamReadData(RamReadData),
    .RamWE      (RamWE),
    .ReadData   (ReadData),
    .bus_valid  (bus_valid),
    .bus_data   (bus_data),
    .bus_ready  (bus_ready)
`ifdef MMIO_STORE_BUFFER_IRQ_EN
    ,
    .irq        (irq)
`endif
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end else
      $display("[TB] ok   %s = %h", name, act);
  endtask

  // Monitor: samples on the falling edge, compares head against the scoreboard.
  always @(negedge clk) begin
    tests++;
    if (bus_valid !== (exp_q.size() != 0)) begin
      fails++;
      $display("FAIL bus_valid: got %b expected %b", bus_valid, exp_q.size() != 0);
    end
    if (bus_valid === 1'b1 && exp_q.size() != 0) begin
      tests++;
      if (bus_data !== exp_q[0]) begin
        fails++;
        $display("FAIL bus_data: got %h expected %h", bus_data, exp_q[0]);
      end
      if (bus_ready) begin
        $display("[TB] pop  bus_data = %h", bus_data);
        void'(exp_q.pop_front());
      end
    end
  end

  task automatic align();
    @(posedge clk);
    #1;
  endtask

  task automatic rd(input string name, input logic [31:0] addr, input logic [31:0] exp);
    MemWrite  = 1'b0;
    ALUResult = addr;
    #1;
    check(name, ReadData, exp);
  endtask

  task automatic store(input logic [31:0] addr, input logic [31:0] data,
                       input bit exp_we, input bit exp_push);
    ALUResult = addr;
    WriteData = data;
    MemWrite  = 1'b1;
    #1;
    check("RamWE", {31'h0, RamWE}, {31'h0, exp_we});
    @(posedge clk);
    if (exp_push) exp_q.push_back(data);
    #1;
    MemWrite = 1'b0;
  endtask

  task automatic drain(input int bound);
    int n = 0;
    bus_ready = 1'b1;
    while (exp_q.size() != 0 && n < bound) begin
      @(posedge clk);
      #1;
      n++;
    end
    tests++;
    if (exp_q.size() != 0) begin
      fails++;
      $display("FAIL drain_timeout: got %0d left expected 0", exp_q.size());
    end
    bus_ready = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset       = 1'b0;
    MemWrite    = 1'b0;
    ALUResult   = 32'h0;
    WriteData   = 32'h0;
    RamReadData = 32'hDEAD_BEEF;
    bus_ready   = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b1;
    align();

    // Idle after reset
    check("reset_valid", {31'h0, bus_valid}, 32'h0);
    check("reset_data", bus_data, 32'h0);
    rd("status_reset", 32'hFFFF_0004, 32'h0000_0002);
    rd("ram_read", 32'h0000_0040, 32'hDEAD_BEEF);
    rd("txdata_read", 32'hFFFF_0000, 32'h0);
    rd("reserved_read", 32'hFFFF_000C, 32'h0);
`ifdef MMIO_STORE_BUFFER_IRQ_EN
    check("irq_reset", {31'h0, irq}, 32'h0);
`endif
    store(32'h0000_0040, 32'h1234_5678, 1'b1, 1'b0);
    rd("status_after_ram_store", 32'hFFFF_0004, 32'h0000_0002);

    // Single push, held with ready low
    store(32'hFFFF_0000, 32'hA5A5_0001, 1'b0, 1'b1);
    rd("status_one", 32'hFFFF_0004, 32'h0000_0100);
    for (int i = 0; i < 5; i++) begin
      align();
      check("hold_data", bus_data, 32'hA5A5_0001);
    end
    align();
    drain(20);
    align();
    rd("status_drained", 32'hFFFF_0004, 32'h0000_0002);

    // Overfill: fifth word dropped
    for (int i = 1; i <= 5; i++) store(32'hFFFF_0000, i, 1'b0, i <= 4);
    rd("status_full_ovf", 32'hFFFF_0004, 32'h0000_0405);
    align();
    drain(20);
    align();
    rd("status_ovf_empty", 32'hFFFF_0004, 32'h0000_0006);
    store(32'hFFFF_0008, 32'h0000_0001, 1'b0, 1'b0);
    rd("status_ovf_cleared", 32'hFFFF_0004, 32'h0000_0002);
    rd("ctrl_read", 32'hFFFF_0008, 32'h0);

    // Full with simultaneous pop and push
    for (int i = 0; i < 4; i++) store(32'hFFFF_0004 - 32'h4, 32'h11 + i, 1'b0, 1'b1);
    rd("status_full", 32'hFFFF_0004, 32'h0000_0401);
    align();
    bus_ready = 1'b1;
    store(32'hFFFF_0000, 32'h99, 1'b0, 1'b1);
    bus_ready = 1'b0;
    rd("status_push_pop_full", 32'hFFFF_0004, 32'h0000_0401);
    align();
    drain(20);
    align();
    rd("status_after_pp", 32'hFFFF_0004, 32'h0000_0002);

    // Reset mid-drain with 3 entries remaining
    for (int i = 0; i < 4; i++) store(32'hFFFF_0000, 32'h31 + i, 1'b0, 1'b1);
    align();
    bus_ready = 1'b1;
    align();
    reset = 1'b0;
    exp_q.delete();
    #1;
    check("midreset_valid", {31'h0, bus_valid}, 32'h0);
    check("midreset_data", bus_data, 32'h0);
    bus_ready = 1'b0;
    align();
    align();
    reset = 1'b1;
    align();
    rd("status_after_reset", 32'hFFFF_0004, 32'h0000_0002);

`ifdef MMIO_STORE_BUFFER_IRQ_EN
    store(32'hFFFF_0008, 32'h0000_0002, 1'b0, 1'b0);
    check("irq_ie_empty", {31'h0, irq}, 32'h1);
    rd("status_ie", 32'hFFFF_0004, 32'h0000_000A);
    store(32'hFFFF_0000, 32'h0000_0077, 1'b0, 1'b1);
    check("irq_after_push", {31'h0, irq}, 32'h0);
    align();
    drain(20);
    align();
    check("irq_after_drain", {31'h0, irq}, 32'h1);
    store(32'hFFFF_0008, 32'h0, 1'b0, 1'b0);
    check("irq_ie_off", {31'h0, irq}, 32'h0);
`endif

    align();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
